// File: rtl/qc_cyclic_shifter_pipe.sv
// rtl/qc_cyclic_shifter_pipe.sv - pipelined modulo-Z cyclic shifter with valid/ready and tag sideband
// A rotation by s within a Z-bit field is split into a right shift and a left shift that are ORed and masked.
module qc_cyclic_shifter_pipe #(
    parameter int MAXZ           = 81,
    parameter int LEVELS_PER_REG = 1,
    parameter int TAG_W          = 8,
    localparam int SW            = $clog2(MAXZ),
    localparam int ZW            = $clog2(MAXZ + 1)
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAXZ-1:0]  in_data,
    input  logic [SW-1:0]    in_shift,
    input  logic [ZW-1:0]    in_z,
    input  logic             in_dir_left,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAXZ-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int NLEV  = SW;
    localparam int DEPTH = (NLEV + LEVELS_PER_REG - 1) / LEVELS_PER_REG;

    function automatic logic [MAXZ-1:0] shr_levels(input logic [MAXZ-1:0] x, input logic [SW-1:0] a,
                                                   input int lo, input int hi);
        logic [MAXZ-1:0] y;
        y = x;
        for (int k = 0; k < SW; k++) begin
            if (k >= lo && k < hi && a[k]) y = y >> (1 << k);
        end
        return y;
    endfunction

    function automatic logic [MAXZ-1:0] shl_levels(input logic [MAXZ-1:0] x, input logic [SW-1:0] a,
                                                   input int lo, input int hi);
        logic [MAXZ-1:0] y;
        y = x;
        for (int k = 0; k < SW; k++) begin
            if (k >= lo && k < hi && a[k]) y = y << (1 << k);
        end
        return y;
    endfunction

    // Index 0 is the entry point; index j+1 is the register output of stage j.
    logic [MAXZ-1:0]  s_r   [DEPTH+1];
    logic [MAXZ-1:0]  s_l   [DEPTH+1];
    logic [MAXZ-1:0]  s_m   [DEPTH+1];
    logic [TAG_W-1:0] s_tag [DEPTH+1];
    logic             s_err [DEPTH+1];
    logic             s_v   [DEPTH+1];
    logic [SW-1:0]    s_ra  [DEPTH];
    logic [SW-1:0]    s_la  [DEPTH];

    logic            adv;
    logic            legal;
    logic [MAXZ-1:0] zmask;
    logic [MAXZ-1:0] ent_mask;
    logic [SW-1:0]   comp_s;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Rotating right by s equals (d >> s) | (d << (Z-s)); left rotation swaps the two amounts.
    always_comb begin
        for (int k = 0; k < MAXZ; k++) zmask[k] = (ZW'(k) < in_z);
        legal    = (in_z != '0) && (in_z <= ZW'(MAXZ)) && (ZW'(in_shift) < in_z);
        comp_s   = (in_shift == '0) ? '0 : (in_z[SW-1:0] - in_shift);
        ent_mask = legal ? zmask : '0;
    end

    assign s_r[0]   = in_data & ent_mask;
    assign s_l[0]   = in_data & ent_mask;
    assign s_m[0]   = ent_mask;
    assign s_tag[0] = in_tag;
    assign s_err[0] = !legal;
    assign s_v[0]   = in_valid;
    assign s_ra[0]  = in_dir_left ? comp_s : in_shift;
    assign s_la[0]  = in_dir_left ? in_shift : comp_s;

    for (genvar j = 0; j < DEPTH; j++) begin : g_stage
        localparam int LO = j * LEVELS_PER_REG;
        localparam int HI = (LO + LEVELS_PER_REG > NLEV) ? NLEV : LO + LEVELS_PER_REG;

        logic [MAXZ-1:0]  r_q, l_q, m_q;
        logic [TAG_W-1:0] tag_q;
        logic             err_q, v_q;

        always_ff @(posedge CLK) begin
            if (!rst_n) begin
                r_q   <= '0;
                l_q   <= '0;
                m_q   <= '0;
                tag_q <= '0;
                err_q <= 1'b0;
                v_q   <= 1'b0;
            end else if (adv) begin
                r_q   <= shr_levels(s_r[j], s_ra[j], LO, HI);
                l_q   <= shl_levels(s_l[j], s_la[j], LO, HI);
                m_q   <= s_m[j];
                tag_q <= s_tag[j];
                err_q <= s_err[j];
                v_q   <= s_v[j];
            end
        end

        assign s_r[j+1]   = r_q;
        assign s_l[j+1]   = l_q;
        assign s_m[j+1]   = m_q;
        assign s_tag[j+1] = tag_q;
        assign s_err[j+1] = err_q;
        assign s_v[j+1]   = v_q;

        // The final stage has no further levels, so it needs no shift amounts.
        if (j < DEPTH - 1) begin : g_amt
            logic [SW-1:0] ra_q, la_q;

            always_ff @(posedge CLK) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    la_q <= '0;
                end else if (adv) begin
                    ra_q <= s_ra[j];
                    la_q <= s_la[j];
                end
            end

            assign s_ra[j+1] = ra_q;
            assign s_la[j+1] = la_q;
        end
    end

    assign out_valid = s_v[DEPTH];
    assign out_data  = (s_r[DEPTH] | s_l[DEPTH]) & s_m[DEPTH];
    assign out_tag   = s_tag[DEPTH];
    assign out_err   = s_err[DEPTH];

endmodule

// File: tb/tb_qc_cyclic_shifter_pipe.sv
// tb/tb_qc_cyclic_shifter_pipe.sv - directed and model-checked bench for qc_cyclic_shifter_pipe
module tb_qc_cyclic_shifter_pipe;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [80:0] in_data;
    logic [6:0]  in_shift;
    logic [6:0]  in_z;
    logic        in_dir_left;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_err;
    logic [80:0] out_data;
    logic [7:0]  out_tag;
    logic        in_ready3, out_valid3, out_err3;
    logic [80:0] out_data3;
    logic [7:0]  out_tag3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    qc_cyclic_shifter_pipe #(.MAXZ(81), .LEVELS_PER_REG(1), .TAG_W(8)) u_dut (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_z(in_z), .in_dir_left(in_dir_left), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_err(out_err)
    );

    qc_cyclic_shifter_pipe #(.MAXZ(81), .LEVELS_PER_REG(3), .TAG_W(8)) u_dut3 (
        .CLK(CLK), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
        .in_shift(in_shift), .in_z(in_z), .in_dir_left(in_dir_left), .in_tag(in_tag),
        .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3), .out_tag(out_tag3),
        .out_err(out_err3)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [80:0] ref_rot(input logic [80:0] d, input int s, input int z, input bit left);
        logic [80:0] r;
        r = '0;
        if (z < 1 || z > 81 || s >= z) return r;
        for (int k = 0; k < z; k++) r[k] = left ? d[(k - s + z) % z] : d[(k + s) % z];
        return r;
    endfunction

    typedef struct {
        logic [80:0] d;
        int          s;
        int          z;
        bit          left;
        logic [80:0] exp;
        bit          err;
    } vec_t;

    typedef struct {
        logic [80:0] d;
        logic [7:0]  tag;
        bit          err;
    } beat_t;

    vec_t  tv[10];
    beat_t exp_q[$];

    task automatic stream(input int n, input bit rnd, input string nm);
        int          sent, got, z, s;
        bit          need_new, held;
        logic [80:0] snap_d;
        logic [7:0]  snap_t;
        beat_t       b;
        sent = 0; got = 0; need_new = 1; held = 0;
        snap_d = '0; snap_t = '0;
        exp_q.delete();
        for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
            @(posedge CLK); #1;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 8 && cyc <= 10);
            if (need_new) begin
                if (sent < n) begin
                    z = $urandom_range(1, 81);
                    s = ($urandom_range(0, 7) == 0) ? z : $urandom_range(0, z - 1);
                    in_z = 7'(z);
                    in_shift = 7'(s);
                    in_dir_left = 1'($urandom_range(0, 1));
                    in_data = {17'($urandom), $urandom, $urandom};
                    in_tag = 8'(sent + 1);
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (held) begin
                chk({nm, "_hold_data"}, out_data, snap_d);
                chk({nm, "_hold_tag"}, out_tag, snap_t);
            end
            held = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk({nm, "_extra_beat"}, 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk({nm, "_data"}, out_data, b.d);
                    chk({nm, "_tag"}, out_tag, b.tag);
                    chk({nm, "_err"}, out_err, b.err);
                end
                got++;
            end else if (out_valid) begin
                chk({nm, "_in_ready_stall"}, in_ready, 0);
                snap_d = out_data;
                snap_t = out_tag;
                held = 1;
            end
            need_new = 0;
            if (in_valid && in_ready) begin
                b.d = ref_rot(in_data, int'(in_shift), int'(in_z), in_dir_left);
                b.tag = in_tag;
                b.err = (s >= z);
                exp_q.push_back(b);
                sent++;
                need_new = 1;
            end else if (!in_valid) begin
                need_new = 1;
            end
        end
        chk({nm, "_count"}, got, n);
        chk({nm, "_left"}, exp_q.size(), 0);
        @(posedge CLK); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        int          lat0, lat3, vcount;
        logic [80:0] d0, d3;
        logic [7:0]  t0;
        logic        e0;
        logic [80:0] ones;

        ones = '1;
        tv[0] = '{81'h03, 1, 5, 1'b0, 81'h11, 1'b0};
        tv[1] = '{81'h03, 1, 5, 1'b1, 81'h06, 1'b0};
        tv[2] = '{81'h01, 80, 81, 1'b0, 81'h02, 1'b0};
        tv[3] = '{ones, 0, 5, 1'b0, 81'h1F, 1'b0};
        tv[4] = '{ones, 5, 5, 1'b0, 81'h0, 1'b1};
        tv[5] = '{ones, 0, 0, 1'b0, 81'h0, 1'b1};
        tv[6] = '{ones, 0, 82, 1'b0, 81'h0, 1'b1};
        tv[7] = '{ones, 0, 1, 1'b1, 81'h1, 1'b0};
        tv[8] = '{81'h1 << 80, 1, 81, 1'b1, 81'h1, 1'b0};
        tv[9] = '{{73'h1ABCDEF, 8'h81}, 3, 8, 1'b0, 81'h30, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_z = '0;
        in_dir_left = 1'b0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            in_data = tv[i].d; in_shift = 7'(tv[i].s); in_z = 7'(tv[i].z);
            in_dir_left = tv[i].left; in_tag = 8'(i + 16); in_valid = 1'b1;
            lat0 = -1; lat3 = -1; d0 = '0; d3 = '0; t0 = '0; e0 = 1'b0;
            for (int cyc = 1; cyc <= 20 && (lat0 < 0 || lat3 < 0); cyc++) begin
                @(posedge CLK); #1;
                in_valid = 1'b0;
                if (out_valid && lat0 < 0) begin
                    lat0 = cyc; d0 = out_data; t0 = out_tag; e0 = out_err;
                end
                if (out_valid3 && lat3 < 0) begin
                    lat3 = cyc; d3 = out_data3;
                end
            end
            chk($sformatf("vec%0d_latency", i), lat0, 7);
            chk($sformatf("vec%0d_latency_l3", i), lat3, 3);
            chk($sformatf("vec%0d_data", i), d0, tv[i].exp);
            chk($sformatf("vec%0d_err", i), e0, tv[i].err);
            chk($sformatf("vec%0d_tag", i), t0, i + 16);
            chk($sformatf("vec%0d_data_l3", i), d3, tv[i].exp);
        end

        stream(6, 1'b0, "stall6");
        stream(40, 1'b1, "rand");

        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            in_data = {17'($urandom), $urandom, $urandom}; in_z = 7'd81; in_shift = 7'(i);
            in_tag = 8'(100 + i); in_valid = 1'b1;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0; rst_n = 1'b0; out_ready = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_tag", out_tag, 0);
        rst_n = 1'b1; out_ready = 1'b1;
        vcount = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge CLK); #1;
            if (out_valid || out_valid3) vcount++;
        end
        chk("midrst_no_ghosts", vcount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
